// File: rtl/cle_key_reader.sv
// cle_key_reader: bus initiator that reads a serial key out of a CLE167 responder.
// On start it requests the board bus, issues N_SYNC sync reads and then NUM_BITS check reads
// in the key window (BA13=0, BA12=1, SSER low, BR_W high). Each check read samples SDRD and
// compares it with a local 6-bit LFSR-style sequence model.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-clock pulse, begins a run when idle
//   busy, done      run in progress / one-clock end-of-run pulse
//   pass, timeout   result flags, held until the next start
//   err_cnt         saturating mismatch count
//   first_err       index of first mismatching check read (8'hFF if none)
//   bus_req/bus_gnt arbiter handshake
//   ba, br_w, sser_n, sdrd  board bus: BA[13:4], read strobe, key-window select, read data
module cle_key_reader #(
  parameter int unsigned NUM_BITS = 64,
  parameter int unsigned N_SYNC   = 8,
  parameter logic [3:0]  SYNC_NIB = 4'hA,
  parameter logic [3:0]  CHK_NIB  = 4'h0,
  parameter logic [5:0]  SEED     = 6'h2D,
  parameter logic [5:0]  TAPS     = 6'h21,
  parameter int unsigned CYC_LEN  = 2,
  parameter int unsigned GNT_TMO  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_cnt,
  output logic [7:0] first_err,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [9:0] ba,
  output logic       br_w,
  output logic       sser_n,
  input  logic       sdrd
);

  typedef enum logic [2:0] {StIdle, StReq, StSync, StCheck, StRel} state_e;

  // BA[13:4] with BA13=0, BA12=1, BA[11:8]=0, BA[7:4]=nibble
  localparam logic [9:0] BaSync = {2'b01, 4'b0000, SYNC_NIB};
  localparam logic [9:0] BaChk  = {2'b01, 4'b0000, CHK_NIB};

  state_e      state;
  logic [15:0] tmo_cnt;
  logic [15:0] cyc_cnt;  // 0..CYC_LEN-1 select low, CYC_LEN is the idle clock
  logic [15:0] rd_cnt;
  logic [5:0]  seq;
  logic        exp_bit;

  assign exp_bit = ^(seq & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= 8'd0;
      first_err <= 8'hFF;
      bus_req   <= 1'b0;
      ba        <= 10'd0;
      br_w      <= 1'b0;
      sser_n    <= 1'b1;
      seq       <= SEED;
      tmo_cnt   <= 16'd0;
      cyc_cnt   <= 16'd0;
      rd_cnt    <= 16'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            err_cnt   <= 8'd0;
            first_err <= 8'hFF;
            timeout   <= 1'b0;
            pass      <= 1'b0;
            seq       <= SEED;
            tmo_cnt   <= 16'd0;
            cyc_cnt   <= 16'd0;
            rd_cnt    <= 16'd0;
            bus_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= StReq;
          end
        end

        StReq: begin
          if (bus_gnt) begin
            state  <= StSync;
            sser_n <= 1'b0;
            br_w   <= 1'b1;
            ba     <= BaSync;
          end else if (tmo_cnt == 16'(GNT_TMO)) begin
            timeout <= 1'b1;
            bus_req <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        StSync, StCheck: begin
          if (cyc_cnt == 16'(CYC_LEN)) begin
            // End of the idle clock: launch the next read or change phase.
            cyc_cnt <= 16'd0;
            if (state == StSync && rd_cnt == 16'(N_SYNC - 1)) begin
              state  <= StCheck;
              rd_cnt <= 16'd0;
              sser_n <= 1'b0;
              ba     <= BaChk;
            end else if (state == StCheck && rd_cnt == 16'(NUM_BITS - 1)) begin
              state <= StRel;
              br_w  <= 1'b0;
              ba    <= 10'd0;
            end else begin
              rd_cnt <= rd_cnt + 16'd1;
              sser_n <= 1'b0;
            end
          end else begin
            if (cyc_cnt == 16'(CYC_LEN - 1)) begin
              // Last clock of the select-low window: sample and release SSER.
              sser_n <= 1'b1;
              if (state == StCheck) begin
                if (sdrd != exp_bit) begin
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  if (first_err == 8'hFF) begin
                    // 8'hFF means "no error", so late indices clamp to 254.
                    first_err <= (rd_cnt > 16'd254) ? 8'd254 : rd_cnt[7:0];
                  end
                end
                seq <= {seq[4:0], exp_bit};
              end
            end
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end

        StRel: begin
          bus_req <= 1'b0;
          sser_n  <= 1'b1;
          br_w    <= 1'b0;
          ba      <= 10'd0;
          done    <= 1'b1;
          pass    <= (err_cnt == 8'd0);
          busy    <= 1'b0;
          state   <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cle_key_reader.sv
module tb_cle_key_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT: default parameters.
  logic       start_m = 1'b0, gnt_m = 1'b0, sdrd_m;
  logic       busy_m, done_m, pass_m, tmo_m, req_m, brw_m, sser_m;
  logic [7:0] err_m, first_m;
  logic [9:0] ba_m;

  cle_key_reader u_dut (
    .clk(clk), .rst(rst), .start(start_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .timeout(tmo_m), .err_cnt(err_m), .first_err(first_m), .bus_req(req_m), .bus_gnt(gnt_m),
    .ba(ba_m), .br_w(brw_m), .sser_n(sser_m), .sdrd(sdrd_m)
  );

  // Long-run DUT: more check reads than the counters can report, to stress saturation/clamp.
  logic       start_b = 1'b0, gnt_b = 1'b0, sdrd_b;
  logic       busy_b, done_b, pass_b, tmo_b, req_b, brw_b, sser_b;
  logic [7:0] err_b, first_b;
  logic [9:0] ba_b;

  cle_key_reader #(.NUM_BITS(300), .N_SYNC(1), .CYC_LEN(1), .GNT_TMO(15)) u_big (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(tmo_b), .err_cnt(err_b), .first_err(first_b), .bus_req(req_b), .bus_gnt(gnt_b),
    .ba(ba_b), .br_w(brw_b), .sser_n(sser_b), .sdrd(sdrd_b)
  );

  // Reference key sequence, built from the seed/tap rule.
  bit key_bits [0:299];
  bit flip_m   [0:63];
  bit flip_b   [0:299];

  // Responder models: index advances once per completed check read.
  bit mon_clr = 1'b0;
  int chk_m, chk_b, nsync_m, nchk_m, badba_m, order_bad_m;
  bit prev_m = 1'b1, prev_b = 1'b1, low_m;

  assign sdrd_m = (chk_m < 64)  ? (key_bits[chk_m] ^ flip_m[chk_m]) : 1'b0;
  assign sdrd_b = (chk_b < 300) ? (key_bits[chk_b] ^ flip_b[chk_b]) : 1'b0;

  always @(posedge clk) begin
    if (mon_clr) begin
      chk_m <= 0; nsync_m <= 0; nchk_m <= 0; badba_m <= 0; order_bad_m <= 0;
      low_m <= 1'b0; prev_m <= 1'b1;
      chk_b <= 0; prev_b <= 1'b1;
    end else begin
      prev_m <= sser_m;
      prev_b <= sser_b;
      if (!sser_m && prev_m) begin
        low_m <= 1'b1;
        if (ba_m[9:4] != 6'b010000 || !brw_m) badba_m <= badba_m + 1;
        if (ba_m[3:0] == 4'hA) begin
          nsync_m <= nsync_m + 1;
          if (nchk_m != 0) order_bad_m <= 1;
        end else if (ba_m[3:0] == 4'h0) begin
          nchk_m <= nchk_m + 1;
        end else begin
          badba_m <= badba_m + 1;
        end
      end
      if (sser_m && !prev_m && ba_m[3:0] == 4'h0) chk_m <= chk_m + 1;
      if (sser_b && !prev_b && ba_b[3:0] == 4'h0) chk_b <= chk_b + 1;
    end
  end

  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  // One main-DUT run: grant after d clocks, grant dropped at drop_at, stray start at dup_at.
  task automatic run_m(input string tag, input int d, input int drop_at, input int dup_at);
    int n, e_err, e_first;
    bit seen;
    e_err = 0; e_first = 255;
    for (int i = 0; i < 64; i++) begin
      if (flip_m[i]) begin
        if (e_first == 255) e_first = i;
        e_err++;
      end
    end
    clear_mon();
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    check({tag, "_busy"}, busy_m, 1);
    check({tag, "_req"}, req_m, 1);
    n = 0; seen = 1'b0;
    while (n < 2000 && !seen) begin
      if (n == d) gnt_m = 1'b1;
      if (n == drop_at) gnt_m = 1'b0;
      start_m = (n == dup_at);
      @(posedge clk); #1;
      n++;
      if (done_m) seen = 1'b1;
    end
    start_m = 1'b0; gnt_m = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, 1 + d + 72 * 3 + 1);
    check({tag, "_pass"}, pass_m, (e_err == 0) ? 1 : 0);
    check({tag, "_err_cnt"}, err_m, e_err);
    check({tag, "_first_err"}, first_m, e_first);
    check({tag, "_timeout"}, tmo_m, 0);
    check({tag, "_req_drop"}, req_m, 0);
    check({tag, "_nsync"}, nsync_m, 8);
    check({tag, "_nchk"}, nchk_m, 64);
    check({tag, "_bus_addr"}, badba_m + order_bad_m, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done_m, 0);
    check({tag, "_idle_bus"}, {busy_m, req_m, brw_m, sser_m, ba_m}, 14'b0001_0000000000);
  endtask

  task automatic run_b(input string tag, input int e_err, input int e_first);
    int n;
    bit seen;
    clear_mon();
    gnt_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 3000 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done_b) seen = 1'b1;
    end
    gnt_b = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, n, 1 + 301 * 2 + 1);
    check({tag, "_err_cnt"}, err_b, e_err);
    check({tag, "_first_err"}, first_b, e_first);
    check({tag, "_pass"}, pass_b, 0);
  endtask

  initial begin
    int s, e, n, cnt, first;
    bit seen;

    s = 6'h2D;
    for (int i = 0; i < 300; i++) begin
      e = ((s & 6'h21) == 6'h01 || (s & 6'h21) == 6'h20) ? 1 : 0;
      key_bits[i] = e[0];
      s = ((s << 1) | e) & 63;
    end
    for (int i = 0; i < 64; i++) flip_m[i] = 1'b0;
    for (int i = 0; i < 300; i++) flip_b[i] = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {busy_m, done_m, pass_m, tmo_m, req_m, brw_m, sser_m}, 7'b0000001);
    check("rst_err_cnt", err_m, 0);
    check("rst_first_err", first_m, 8'hFF);
    check("rst_ba", ba_m, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean run, grant at once, stray start mid-run.
    run_m("clean", 0, -1, 40);

    // Flipped check reads 5 and 9.
    flip_m[5] = 1'b1; flip_m[9] = 1'b1;
    run_m("flip5_9", $urandom_range(0, 5), -1, -1);

    // Randomized runs with grant delay, grant drop and stray start.
    for (int r = 0; r < 4; r++) begin
      int d;
      for (int i = 0; i < 64; i++) flip_m[i] = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 20);
      run_m($sformatf("rand%0d", r), d, d + 1 + $urandom_range(0, 100), $urandom_range(1, 150));
    end

    // Grant never arrives.
    clear_mon();
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 1000 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done_m) seen = 1'b1;
    end
    check("tmo_done_seen", seen, 1);
    check("tmo_latency", n, 256);
    check("tmo_flag", tmo_m, 1);
    check("tmo_pass", pass_m, 0);
    check("tmo_req", req_m, 0);
    check("tmo_no_sser", low_m, 0);

    // Reset in the middle of the check phase.
    for (int i = 0; i < 64; i++) flip_m[i] = 1'b0;
    flip_m[5] = 1'b1; flip_m[9] = 1'b1;
    clear_mon();
    gnt_m = 1'b1;
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    check("restart_clears_tmo", tmo_m, 0);
    repeat (100) @(posedge clk);
    #1;
    check("midrun_err_before_rst", err_m, 2);
    rst = 1'b1;
    #2;
    check("midrst_flags", {busy_m, done_m, pass_m, tmo_m, req_m, brw_m, sser_m}, 7'b0000001);
    check("midrst_err", {err_m, first_m}, 16'h00FF);
    check("midrst_ba", ba_m, 0);
    gnt_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Long run: every check read wrong, so the count must saturate.
    for (int i = 0; i < 300; i++) flip_b[i] = 1'b1;
    run_b("sat", 255, 0);

    // Long run: first error beyond the reportable range.
    for (int i = 0; i < 300; i++) flip_b[i] = (i >= 270);
    cnt = 0; first = 255;
    for (int i = 0; i < 300; i++) begin
      if (flip_b[i]) begin
        if (first == 255) first = (i > 254) ? 254 : i;
        cnt++;
      end
    end
    run_b("clamp", (cnt > 255) ? 255 : cnt, first);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
